// File: rtl/bcd_conv_arbiter.sv
// Shares one shift-and-add-3 binary-to-BCD converter (8 steps) among NREQ requesters.
// Define BCD_CONV_ARB_RR_EN for round-robin arbitration; otherwise the lowest index wins.
module bcd_conv_arbiter #(
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] bin_in,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic [11:0]       bcd_out,
  output logic              busy
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t            state;
  logic [PW-1:0]     owner;
  logic [PW-1:0]     win;
  logic [2:0]        cnt;
  logic [19:0]       shreg;
  logic [19:0]       adj;
  logic [19:0]       shreg_nxt;
  logic [NREQ-1:0]   win_oh;
  logic [NREQ-1:0]   owner_oh;
  logic [7:0]        win_bin;

`ifdef BCD_CONV_ARB_RR_EN
  logic [PW-1:0] ptr;
  logic          found;

  // Rotating search starting just after the last served requester.
  always_comb begin
    int idx;
    idx   = 0;
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx[PW-1:0];
      end
    end
  end
`else
  // Descending scan so the lowest requesting index is the final assignment.
  always_comb begin
    win = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req[i]) win = PW'(i);
  end
`endif

  always_comb begin
    win_oh   = '0;
    owner_oh = '0;
    win_bin  = '0;
    for (int i = 0; i < NREQ; i++) begin
      win_oh[i]   = (win == PW'(i));
      owner_oh[i] = (owner == PW'(i));
      if (win == PW'(i)) win_bin = bin_in[i*8 +: 8];
    end
  end

  // One double-dabble step: correct each BCD digit that would overflow, then shift.
  always_comb begin
    adj = shreg;
    for (int d = 0; d < 3; d++)
      if (adj[8+4*d +: 4] >= 4'd5) adj[8+4*d +: 4] = adj[8+4*d +: 4] + 4'd3;
    shreg_nxt = {adj[18:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant   <= '0;
      done    <= '0;
      bcd_out <= '0;
      shreg   <= '0;
      owner   <= '0;
      cnt     <= '0;
`ifdef BCD_CONV_ARB_RR_EN
      ptr     <= PW'(NREQ - 1);
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant <= win_oh;
            owner <= win;
            shreg <= {12'd0, win_bin};
            cnt   <= '0;
            state <= CONV;
          end
        end
        CONV: begin
          grant <= '0;
          shreg <= shreg_nxt;
          cnt   <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            bcd_out <= shreg_nxt[19:8];
            done    <= owner_oh;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= '0;
`ifdef BCD_CONV_ARB_RR_EN
          ptr   <= owner;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed + randomized bench for bcd_conv_arbiter against a decimal/arbitration reference model.
module tb_bcd_conv_arbiter;
  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*8-1:0] bin_in = '0;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic [11:0]       bcd_out;
  logic              busy;

  int errors = 0;
  int checks = 0;
  int m_last = NREQ - 1;
  int cyc = 0;

  bcd_conv_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .bin_in(bin_in),
    .grant(grant), .done(done), .bcd_out(bcd_out), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] r;
    r = '0;
    if (i >= 0 && i < NREQ) r[i] = 1'b1;
    return r;
  endfunction

  function automatic int exp_win(input logic [NREQ-1:0] r);
`ifdef BCD_CONV_ARB_RR_EN
    for (int k = 1; k <= NREQ; k++)
      if (r[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
`else
    for (int i = 0; i < NREQ; i++)
      if (r[i]) return i;
`endif
    return -1;
  endfunction

  // grant/done exclusivity and one-hotness on every cycle out of reset
  always @(negedge clk)
    if (rst_n)
      chk("exclusive", 32'(((grant & done) != '0) || !$onehot0(grant) || !$onehot0(done)), 32'd0);

  task automatic serve(output int w, output int waits, output logic [7:0] v);
    int e;
    w = -1; waits = 0; v = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      waits++;
      if (grant != '0) break;
    end
    if (grant == '0) begin
      checks++; errors++;
      $error("FAIL grant_timeout: got %0h expected a grant", grant);
    end else begin
      e = exp_win(req);
      chk("grant", 32'(grant), 32'(onehot(e)));
      chk("busy_grant", 32'(busy), 32'd1);
      w = e;
      if (e >= 0) v = bin_in[8*e +: 8];
    end
  endtask

  task automatic finish_conv(input int w, input logic [7:0] v, output int dcyc);
    logic [11:0] old;
    old = bcd_out;
    dcyc = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k < 8) begin
        chk("busy_conv", 32'(busy), 32'd1);
        chk("done_early", 32'(done), 32'd0);
        chk("bcd_hold", 32'(bcd_out), 32'(old));
        chk("grant_clr", 32'(grant), 32'd0);
      end else begin
        chk("done_onehot", 32'(done), 32'(onehot(w)));
        chk("bcd_result", 32'(bcd_out), 32'(ref_bcd(int'(v))));
        chk("busy_done", 32'(busy), 32'd1);
      end
    end
    dcyc = cyc;
    if (w >= 0) m_last = w;
    @(negedge clk);
    chk("done_clr", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w, waits, dc, prev_dc, g2, d0, ew;
    logic [7:0] v;
    logic [11:0] held;

    // reset state
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd", 32'(bcd_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // single conversion
    req[0] = 1'b1; bin_in[7:0] = 8'd59;
    serve(w, waits, v);
    chk("grant_latency", 32'(waits), 32'd1);
    req[0] = 1'b0;
    finish_conv(w, v, dc);
    chk("single_bcd", 32'(bcd_out), 32'h059);

    // exhaustive values on requester 1, back-to-back
    req[1] = 1'b1; bin_in[15:8] = 8'd0; prev_dc = 0;
    for (int n = 0; n < 256; n++) begin
      serve(w, waits, v);
      chk("exh_owner", 32'(w), 32'd1);
      chk("exh_value", 32'(v), 32'(n));
      if (n == 255) req[1] = 1'b0;
      else bin_in[15:8] = 8'(n + 1);
      finish_conv(w, v, dc);
      if (n > 0) chk("exh_spacing", 32'(dc - prev_dc), 32'd10);
      prev_dc = dc;
    end

    // reset during conversion step 4
    req[3] = 1'b1; bin_in[31:24] = 8'd200;
    serve(w, waits, v);
    req[3] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_grant", 32'(grant), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_bcd", 32'(bcd_out), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    m_last = NREQ - 1;
    @(negedge clk);
    rst_n = 1'b1;
    d0 = 0;
    repeat (12) begin
      @(negedge clk);
      if (done != '0 || busy) d0++;
    end
    chk("no_done_after_rst", 32'(d0), 32'd0);
    req[2] = 1'b1; bin_in[23:16] = 8'd123;
    serve(w, waits, v);
    req[2] = 1'b0;
    finish_conv(w, v, dc);

    // withdrawal: req[2] raised while busy and dropped before any grant
    req[0] = 1'b1; bin_in[7:0] = 8'd7;
    serve(w, waits, v);
    req[0] = 1'b0; req[2] = 1'b1;
    repeat (3) @(negedge clk);
    req[2] = 1'b0;
    g2 = 0; d0 = 0;
    repeat (20) begin
      @(negedge clk);
      if (grant[2]) g2++;
      if (done[0]) d0++;
    end
    chk("withdraw_no_grant", 32'(g2), 32'd0);
    chk("withdraw_done0", 32'(d0), 32'd1);
    chk("withdraw_bcd", 32'(bcd_out), 32'h007);
    m_last = 0;

    // bin_in sampled only at the grant edge
    req[3] = 1'b1; bin_in[31:24] = 8'd45;
    serve(w, waits, v);
    bin_in[31:24] = 8'd200; req[3] = 1'b0;
    finish_conv(w, 8'd45, dc);
    held = bcd_out;
    chk("stable_bcd", 32'(held), 32'h045);

    // arbitration with all requesters held
    req = '1;
    bin_in = {8'd40, 8'd30, 8'd20, 8'd10};
    for (int k = 0; k < 6; k++) begin
      serve(w, waits, v);
`ifdef BCD_CONV_ARB_RR_EN
      ew = k % NREQ;
`else
      ew = 0;
`endif
      chk("arb_order", 32'(w), 32'(ew));
      if (k == 5) req = '0;
      finish_conv(w, v, dc);
      chk("arb_bcd", 32'(bcd_out), 32'(ref_bcd(10 * (ew + 1))));
    end

    // randomized traffic against the model
    for (int it = 0; it < 40; it++) begin
      if (req == '0) begin
        req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
        for (int i = 0; i < NREQ; i++) bin_in[8*i +: 8] = 8'($urandom);
      end
      serve(w, waits, v);
      for (int i = 0; i < NREQ; i++) begin
        if (i == w || !req[i]) begin
          req[i] = 1'($urandom_range(0, 1));
          bin_in[8*i +: 8] = 8'($urandom);
        end
      end
      finish_conv(w, v, dc);
    end
    req = '0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
